// File: rtl/vision_pkg.sv
// -----------------------------------------------------------------------------
// vision_pkg
//   Shared types for the streaming vision stages.
//   - pixel_t      : default-width pixel word
//   - PIX_EDGE/BG  : binary-map pixel values for the default width
//   - pos_t        : raster position {col,row}
//   - pos_advance  : raster-order step with wrap at the line/frame end
// -----------------------------------------------------------------------------
package vision_pkg;

    localparam int PIX_W = 8;
    localparam int POS_W = 16;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam pixel_t PIX_EDGE = '1;
    localparam pixel_t PIX_BG   = '0;

    typedef struct packed {
        logic [POS_W-1:0] col;
        logic [POS_W-1:0] row;
    } pos_t;

    // Step one pixel in raster order; col wraps into the next row and the
    // row wraps back to the top of the frame.
    function automatic pos_t pos_advance(input pos_t p,
                                         input logic [POS_W-1:0] last_col,
                                         input logic [POS_W-1:0] last_row);
        pos_t n;
        n = p;
        if (p.col == last_col) begin
            n.col = '0;
            n.row = (p.row == last_row) ? '0 : p.row + POS_W'(1);
        end else begin
            n.col = p.col + POS_W'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// -----------------------------------------------------------------------------
// stream_skid_buffer
//   Two-entry valid/ready register slice: an output register plus a skid
//   register that catches the beat accepted while the output is stalled.
//   in_ready depends only on registered state (skid register empty).
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_data  [DW]       : upstream data
//   out_valid/out_ready : downstream handshake
//   out_data [DW]       : downstream data, stable while out_valid && !out_ready
// -----------------------------------------------------------------------------
module stream_skid_buffer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          skid_valid;
    logic [DW-1:0] skid_data;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_ready || !out_valid) begin
            // Output slot frees up: refill from skid first to keep order.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && !skid_valid) begin
            // Output stalled: park the accepted beat in the skid register.
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/edge_binarizer.sv
// -----------------------------------------------------------------------------
// edge_binarizer
//   Thresholds filtered pixels into a binary edge map (all-ones / zero),
//   forces a BORDER-pixel frame margin to background, counts edge pixels per
//   frame and publishes the total with a one-cycle frame_done pulse.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   x_valid/x_ready     : input handshake (x_ready registered)
//   x_data   [W]        : filtered pixel, unsigned, raster order
//   threshold[W]        : edge threshold, sampled on the pixel at (0,0)
//   y_valid/y_ready     : output handshake
//   y_data   [W]        : binary pixel
//   edge_count[CNT_W]   : edge total of the last completed frame
//   frame_done          : one-cycle pulse when edge_count updates
// -----------------------------------------------------------------------------
module edge_binarizer
    import vision_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int W          = 8,
    parameter int BORDER     = 1,
    parameter int CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [W-1:0]     x_data,
    input  logic [W-1:0]     threshold,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [W-1:0]     y_data,
    output logic [CNT_W-1:0] edge_count,
    output logic             frame_done
);

    localparam logic [POS_W-1:0] LAST_COL = POS_W'(IMG_WIDTH - 1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(IMG_HEIGHT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pos_t             pos;
    logic [W-1:0]     thr_q;
    logic [W-1:0]     thr_eff;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] next_total;
    logic             x_hs;
    logic             at_origin;
    logic             last_px;
    logic             in_border;
    logic             is_edge;
    logic [W-1:0]     pix_bin;

    assign x_hs      = x_valid && x_ready;
    assign at_origin = (pos.col == '0) && (pos.row == '0);
    assign last_px   = (pos.col == LAST_COL) && (pos.row == LAST_ROW);

    // The first pixel of a frame already uses the threshold being sampled.
    assign thr_eff = at_origin ? threshold : thr_q;

    generate
        if (BORDER == 0) begin : g_no_border
            assign in_border = 1'b0;
        end else begin : g_border
            localparam logic [POS_W-1:0] B_LO   = POS_W'(BORDER);
            localparam logic [POS_W-1:0] COL_HI = POS_W'(IMG_WIDTH - BORDER);
            localparam logic [POS_W-1:0] ROW_HI = POS_W'(IMG_HEIGHT - BORDER);
            assign in_border = (pos.col < B_LO) || (pos.col >= COL_HI) ||
                               (pos.row < B_LO) || (pos.row >= ROW_HI);
        end
    endgenerate

    assign is_edge    = (x_data >= thr_eff) && !in_border;
    assign pix_bin    = is_edge ? {W{1'b1}} : '0;
    assign next_total = is_edge ? sat_inc(run_cnt) : run_cnt;

    // Position, threshold capture and edge counting on each input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos        <= '0;
            thr_q      <= '0;
            run_cnt    <= '0;
            edge_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= x_hs && last_px;
            if (x_hs) begin
                pos <= pos_advance(pos, LAST_COL, LAST_ROW);
                if (at_origin) begin
                    thr_q <= threshold;
                end
                if (last_px) begin
                    edge_count <= next_total;
                    run_cnt    <= '0;
                end else begin
                    run_cnt <= next_total;
                end
            end
        end
    end

    // Output register slice.
    stream_skid_buffer #(
        .DW(W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (x_valid),
        .in_ready (x_ready),
        .in_data  (pix_bin),
        .out_valid(y_valid),
        .out_ready(y_ready),
        .out_data (y_data)
    );

endmodule
